us_arp_cache: RTL

Parametrised multi-entry ARP cache with an integrated resolver, successor to the single-entry ARP table in the UDP 10G stack. It learns IP→MAC bindings from received ARP replies and requests, answers TX-path lookups with a fixed one-cycle latency, and ages out stale entries. On a lookup miss it drives the ARP TX block with request, timeout and retry handling, and reports unresolved addresses. It sits between the ARP RX/TX blocks and the IP/UDP TX header builder.

---
 rtl/us_arp_cache.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/us_arp_cache.sv
`default_nettype none
// ============================================================================
// Module  : us_arp_cache
// Brief   : Multi-entry ARP cache with aging and an ARP request resolver.
// Revision: 1.0 - initial release
// ============================================================================
module us_arp_cache #(
    parameter int DEPTH              = 8,
    parameter int REQ_TIMEOUT_CYCLES = 156250000,
    parameter int MAX_RETRY          = 3,
    parameter int AGE_TICK_CYCLES    = 156250000,
    parameter int AGE_MAX            = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     learn_valid,
    input  logic [31:0]              learn_ip,
    input  logic [47:0]              learn_mac,
    input  logic                     lookup_req,
    input  logic [31:0]              lookup_ip,
    output logic                     lookup_ack,
    output logic                     lookup_hit,
    output logic [47:0]              lookup_mac,
    output logic                     arp_request_req,
    output logic [31:0]              arp_request_ip,
    input  logic                     arp_request_ack,
    output logic                     resolve_fail,
    output logic                     resolver_busy,
    output logic [$clog2(DEPTH):0]   entry_count
);

    localparam int          c_idx_w    = $clog2(DEPTH);
    localparam int          c_tmr_w    = $clog2(REQ_TIMEOUT_CYCLES + 1);
    localparam int          c_pre_w    = $clog2(AGE_TICK_CYCLES + 1);
    localparam logic [47:0] c_mac_none = '1;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_wait = 2'd2;
    localparam logic [1:0] c_st_fail = 2'd3;

    logic [DEPTH-1:0]   r_valid;
    logic [31:0]        r_ip  [DEPTH];
    logic [47:0]        r_mac [DEPTH];
    logic [7:0]         r_age [DEPTH];
    logic [c_idx_w-1:0] r_repl_ptr;
    logic [c_pre_w-1:0] r_pre_cnt;
    logic [31:0]        r_lu_ip;

    logic [1:0]         r_state;
    logic [c_tmr_w-1:0] r_timer;
    logic [3:0]         r_retry;
    logic               r_reply_seen;

    logic               w_learn_ok;
    logic               w_learn_hit;
    logic               w_free_any;
    logic               w_tick;
    logic [c_idx_w-1:0] w_hit_idx;
    logic [c_idx_w-1:0] w_free_idx;
    logic [c_idx_w-1:0] w_wr_idx;
    logic [DEPTH-1:0]   w_wr_sel;
    logic [DEPTH-1:0]   w_valid_nxt;
    logic [c_idx_w:0]   w_count_nxt;
    logic               w_lu_hit;
    logic [47:0]        w_lu_mac;
    logic               w_reply;

    assign w_tick = (r_pre_cnt == c_pre_w'(AGE_TICK_CYCLES - 1));

    // Descending scan so the lowest-index free slot is the one that sticks.
    always_comb begin
        w_learn_ok  = learn_valid && (learn_ip != 32'd0) && (learn_mac != c_mac_none);
        w_learn_hit = 1'b0;
        w_hit_idx   = '0;
        w_free_any  = 1'b0;
        w_free_idx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_ip[i] == learn_ip)) begin
                w_learn_hit = 1'b1;
                w_hit_idx   = c_idx_w'(i);
            end
            if (!r_valid[i]) begin
                w_free_any = 1'b1;
                w_free_idx = c_idx_w'(i);
            end
        end
        if (w_learn_hit)
            w_wr_idx = w_hit_idx;
        else if (w_free_any)
            w_wr_idx = w_free_idx;
        else
            w_wr_idx = r_repl_ptr;
        w_wr_sel = '0;
        if (w_learn_ok)
            w_wr_sel[w_wr_idx] = 1'b1;
    end

    // A learn on an entry overrides any expiry from a coincident tick.
    always_comb begin
        w_valid_nxt = r_valid;
        w_count_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_wr_sel[i])
                w_valid_nxt[i] = 1'b1;
            else if (w_tick && r_valid[i] && (r_age[i] == 8'(AGE_MAX)))
                w_valid_nxt[i] = 1'b0;
            w_count_nxt = w_count_nxt + {{c_idx_w{1'b0}}, w_valid_nxt[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= '0;
            r_repl_ptr  <= '0;
            r_pre_cnt   <= '0;
            entry_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ip[i]  <= '0;
                r_mac[i] <= '0;
                r_age[i] <= '0;
            end
        end else begin
            r_valid     <= w_valid_nxt;
            entry_count <= w_count_nxt;
            r_pre_cnt   <= w_tick ? '0 : r_pre_cnt + c_pre_w'(1);
            if (w_learn_ok && !w_learn_hit && !w_free_any)
                r_repl_ptr <= r_repl_ptr + c_idx_w'(1);
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wr_sel[i]) begin
                    r_ip[i]  <= learn_ip;
                    r_mac[i] <= learn_mac;
                    r_age[i] <= 8'd0;
                end else if (w_tick && r_valid[i]) begin
                    r_age[i] <= r_age[i] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        w_lu_hit = 1'b0;
        w_lu_mac = c_mac_none;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_ip[i] == lookup_ip)) begin
                w_lu_hit = 1'b1;
                w_lu_mac = r_mac[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lookup_ack <= 1'b0;
            lookup_hit <= 1'b0;
            lookup_mac <= c_mac_none;
            r_lu_ip    <= '0;
        end else begin
            lookup_ack <= lookup_req;
            lookup_hit <= lookup_req && w_lu_hit;
            lookup_mac <= (lookup_req && w_lu_hit) ? w_lu_mac : c_mac_none;
            if (lookup_req)
                r_lu_ip <= lookup_ip;
        end
    end

    assign w_reply = w_learn_ok && (learn_ip == arp_request_ip);

    // A reply seen during REQ is remembered so the handshake can finish first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_st_idle;
            r_timer        <= '0;
            r_retry        <= 4'd0;
            r_reply_seen   <= 1'b0;
            arp_request_ip <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (lookup_ack && !lookup_hit) begin
                        r_state        <= c_st_req;
                        arp_request_ip <= r_lu_ip;
                        r_retry        <= 4'd1;
                        r_reply_seen   <= 1'b0;
                    end
                end
                c_st_req: begin
                    if (w_reply)
                        r_reply_seen <= 1'b1;
                    if (arp_request_ack) begin
                        r_state <= (r_reply_seen || w_reply) ? c_st_idle : c_st_wait;
                        r_timer <= '0;
                    end
                end
                c_st_wait: begin
                    if (w_reply) begin
                        r_state <= c_st_idle;
                    end else if (r_timer == c_tmr_w'(REQ_TIMEOUT_CYCLES - 1)) begin
                        if (r_retry < 4'(MAX_RETRY)) begin
                            r_state      <= c_st_req;
                            r_retry      <= r_retry + 4'd1;
                            r_reply_seen <= 1'b0;
                        end else begin
                            r_state <= c_st_fail;
                        end
                    end else begin
                        r_timer <= r_timer + c_tmr_w'(1);
                    end
                end
                c_st_fail: r_state <= c_st_idle;
                default:   r_state <= c_st_idle;
            endcase
        end
    end

    assign arp_request_req = (r_state == c_st_req);
    assign resolve_fail    = (r_state == c_st_fail);
    assign resolver_busy   = (r_state != c_st_idle);

endmodule
`default_nettype wire
